// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cam_pkg
//  Description : Shared definitions for the OV7670-style stream generator:
//                FSM state encoding, RGB332 / RGB565 field widths and the
//                RGB332 -> RGB565 expansion function.
//  Contents    : cam_state_t         - stream generator FSM states
//                c_*_w               - colour field widths
//                expand_332_to_565() - returns {byte0, byte1} of a pixel
//  Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBP    = 3'd2,
        ACTIVE = 3'd3,
        HBLANK = 3'd4,
        VFP    = 3'd5
    } cam_state_t;

    localparam int c_r332_w = 3;
    localparam int c_g332_w = 3;
    localparam int c_b332_w = 2;
    localparam int c_r565_w = 5;
    localparam int c_g565_w = 6;
    localparam int c_b565_w = 5;

    // Widening replicates the most significant bits into the new low bits,
    // so full-scale stays full-scale and zero stays zero.
    function automatic logic [15:0] expand_332_to_565(input logic [7:0] pix);
        logic [c_r332_w-1:0] r;
        logic [c_g332_w-1:0] g;
        logic [c_b332_w-1:0] b;
        logic [c_r565_w-1:0] r5;
        logic [c_g565_w-1:0] g6;
        logic [c_b565_w-1:0] b5;
        r  = pix[7:5];
        g  = pix[4:2];
        b  = pix[1:0];
        r5 = {r, r[2:1]};
        g6 = {g, g};
        b5 = {b, b, b[1]};
        return {r5, g6, b5};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb332_to_565.sv
`default_nettype none
// ============================================================================
//  Module      : rgb332_to_565
//  Description : Combinational RGB332 -> RGB565 expansion, split into the two
//                camera bytes in transmit order.
//  Ports       : i_pix    [7:0] - RGB332 pixel {R[2:0],G[2:0],B[1:0]}
//                o_byte0  [7:0] - {R5, G6[5:3]}  (sent first)
//                o_byte1  [7:0] - {G6[2:0], B5}  (sent second)
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb332_to_565
    import cam_pkg::*;
(
    input  logic [7:0] i_pix,
    output logic [7:0] o_byte0,
    output logic [7:0] o_byte1
);

    assign {o_byte0, o_byte1} = expand_332_to_565(i_pix);

endmodule
`default_nettype wire

// File: rtl/ov7670_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_stream_gen
//  Description : Synthetic OV7670-style camera. Reads RGB332 pixels from a
//                frame buffer (1-clock read latency) and emits an RGB565 byte
//                stream framed by vsync/href, two bytes per pixel.
//  Ports       : pclk        - clock, all outputs change on its rising edge
//                in_reset    - synchronous active-high reset
//                enable      - start / keep repeating frames
//                rd_addr     - frame-buffer read address (linear per frame)
//                rd_en       - read strobe, one clock before each byte 0
//                rd_data     - RGB332 pixel, valid the clock after rd_en
//                vsync, href - frame / line framing
//                data_out    - camera byte, 0 whenever href is low
//                frame_done  - pulse on the last clock of each frame
//                busy        - high whenever the FSM is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module ov7670_stream_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = 160,
    parameter int V_ACTIVE    = 120,
    parameter int H_BLANK     = 16,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 2,
    parameter int VFP_LINES   = 2,
    parameter int AW          = 15
) (
    input  logic          pclk,
    input  logic          in_reset,
    input  logic          enable,
    output logic [AW-1:0] rd_addr,
    output logic          rd_en,
    input  logic [7:0]    rd_data,
    output logic          vsync,
    output logic          href,
    output logic [7:0]    data_out,
    output logic          frame_done,
    output logic          busy
);

    localparam int c_line_len  = 2 * H_ACTIVE + H_BLANK;
    localparam int c_col_w     = $clog2(c_line_len);
    localparam int c_max_ab    = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
    localparam int c_max_cd    = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
    localparam int c_max_lines = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int c_line_w    = $clog2(c_max_lines + 1);

    localparam logic [c_col_w-1:0]  c_col_last     = c_col_w'(c_line_len - 1);
    localparam logic [c_col_w-1:0]  c_col_act_last = c_col_w'(2 * H_ACTIVE - 1);
    localparam logic [c_line_w-1:0] c_vs_last      = c_line_w'(VSYNC_LINES - 1);
    localparam logic [c_line_w-1:0] c_vbp_last     = c_line_w'(VBP_LINES - 1);
    localparam logic [c_line_w-1:0] c_vfp_last     = c_line_w'(VFP_LINES - 1);
    localparam logic [c_line_w-1:0] c_act_last     = c_line_w'(V_ACTIVE - 1);

    cam_state_t          r_state;
    cam_state_t          w_state_nxt;
    logic [c_col_w-1:0]  r_col;
    logic [c_col_w-1:0]  w_col_nxt;
    logic [c_line_w-1:0] r_line;
    logic [c_line_w-1:0] w_line_nxt;
    logic [c_line_w-1:0] w_seg_last;
    logic [AW-1:0]       r_addr;
    logic [7:0]          r_pix;
    logic [7:0]          w_pix_sel;
    logic [7:0]          w_byte0;
    logic [7:0]          w_byte1;
    logic                r_bsel;
    logic                w_col_end;
    logic                w_seg_end;
    logic                w_rd_en;

    // ------------------------------------------------------------------
    // State, counters, address and pixel registers
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (in_reset) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_line  <= '0;
            r_bsel  <= 1'b0;
            r_addr  <= '0;
            r_pix   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_line  <= w_line_nxt;
            // Byte select is 0 on the first ACTIVE clock of every line.
            r_bsel  <= (r_state == ACTIVE) ? ~r_bsel : 1'b0;
            if ((w_state_nxt == VSYNC) && (r_state != VSYNC)) begin
                r_addr <= '0;
            end else if (w_rd_en) begin
                r_addr <= r_addr + 1'b1;
            end
            if ((r_state == ACTIVE) && !r_bsel) begin
                r_pix <= rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state, counter and read-strobe logic
    // ------------------------------------------------------------------
    always_comb begin
        w_col_end = (r_col == c_col_last);
        case (r_state)
            VSYNC:          w_seg_last = c_vs_last;
            VBP:            w_seg_last = c_vbp_last;
            ACTIVE, HBLANK: w_seg_last = c_act_last;
            VFP:            w_seg_last = c_vfp_last;
            default:        w_seg_last = '0;
        endcase
        w_seg_end = w_col_end && (r_line == w_seg_last);

        w_state_nxt = r_state;
        w_col_nxt   = r_col + 1'b1;
        w_line_nxt  = r_line;
        w_rd_en     = 1'b0;

        case (r_state)
            IDLE: begin
                w_col_nxt  = '0;
                w_line_nxt = '0;
                if (enable) begin
                    w_state_nxt = VSYNC;
                end
            end
            VSYNC, VBP, VFP: begin
                if (w_col_end) begin
                    w_col_nxt = '0;
                    if (w_seg_end) begin
                        w_line_nxt = '0;
                    end else begin
                        w_line_nxt = r_line + 1'b1;
                    end
                end
                if (w_seg_end) begin
                    if (r_state == VSYNC) begin
                        w_state_nxt = VBP;
                    end else if (r_state == VBP) begin
                        w_state_nxt = ACTIVE;
                        w_rd_en     = 1'b1;   // prefetch pixel 0
                    end else begin
                        w_state_nxt = enable ? VSYNC : IDLE;
                    end
                end
            end
            ACTIVE: begin
                // Fetch the next pixel during byte 1 of the current one,
                // except after the last pixel of the line.
                w_rd_en = r_bsel && (r_col != c_col_act_last);
                if (r_col == c_col_act_last) begin
                    w_state_nxt = HBLANK;
                end
            end
            HBLANK: begin
                // Column keeps counting through the blanking so w_col_end
                // marks the end of the whole line period.
                if (w_col_end) begin
                    w_col_nxt = '0;
                    if (w_seg_end) begin
                        w_line_nxt  = '0;
                        w_state_nxt = VFP;
                    end else begin
                        w_line_nxt  = r_line + 1'b1;
                        w_state_nxt = ACTIVE;
                        w_rd_en     = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_col_nxt   = '0;
                w_line_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel path. Byte 0 coincides with the clock in which the RAM presents
    // the pixel, so it is taken straight from rd_data; byte 1 uses the copy
    // captured at the end of that clock.
    // ------------------------------------------------------------------
    assign w_pix_sel = r_bsel ? r_pix : rd_data;

    rgb332_to_565 u_cvt (
        .i_pix   (w_pix_sel),
        .o_byte0 (w_byte0),
        .o_byte1 (w_byte1)
    );

    assign rd_addr    = r_addr;
    assign rd_en      = w_rd_en;
    assign vsync      = (r_state == VSYNC);
    assign href       = (r_state == ACTIVE);
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == VFP) && w_seg_end;
    assign data_out   = href ? (r_bsel ? w_byte1 : w_byte0) : 8'h00;

endmodule
`default_nettype wire
